// File: rtl/fetch_unit.sv
// Instruction fetch stage: assembles 16-bit instructions from a byte-wide memory,
// high byte first, and hands them to decode under a valid/ready handshake.
module fetch_unit #(
  parameter int             AW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic [15:0]   inst,
  output logic [3:0]    opcode,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_HI  = 2'd0,
    S_LO  = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_inc;

  // AW-bit add: the PC wraps naturally, so a fetch may straddle the top of memory
  assign pc_inc = pc + {{(AW-1){1'b0}}, 1'b1};
  assign opcode = inst[15:12];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_HI;
      pc         <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else if (redirect) begin
      // Redirect outranks ack and ready; any byte returned this cycle is dropped
      state      <= S_HI;
      pc         <= redirect_pc;
      mem_addr   <= redirect_pc;
      mem_req    <= 1'b1;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        S_HI: begin
          if (!mem_req) begin
            // Only reached straight out of reset
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ack) begin
            inst[15:8] <= mem_rdata;
            inst_pc    <= pc;
            pc         <= pc_inc;
            mem_addr   <= pc_inc;
            state      <= S_LO;
          end
        end
        S_LO: begin
          if (mem_ack) begin
            inst[7:0]  <= mem_rdata;
            pc         <= pc_inc;
            inst_valid <= 1'b1;
            mem_req    <= 1'b0;
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            mem_req    <= 1'b1;
            mem_addr   <= pc;
            state      <= S_HI;
          end
        end
        default: state <= S_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: byte memory model with programmable wait states,
// one task per scenario with hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] inst;
  logic [3:0]  opcode;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];
  int waits = 0;
  int wcnt;

  fetch_unit #(.AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst(inst), .opcode(opcode), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory acks after 'waits' idle request cycles per byte
  assign mem_ack   = mem_req && (wcnt >= waits);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst)                 wcnt <= 0;
    else if (!mem_req)       wcnt <= 0;
    else if (mem_ack)        wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    waits = 0; inst_ready = 1'b1;
    rst = 1'b1;
    step();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", mem_addr); end
    checks++; if (inst !== 16'h0000) begin failures++; $display("FAIL reset_inst got=%h exp=0000", inst); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    checks++; if (inst_pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", inst_pc); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    waits = 0; inst_ready = 1'b1;
    do_reset();
    step();
    checks++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 8'h00, 1'b0}) begin failures++; $display("FAIL basic_e1 got req=%b addr=%h v=%b exp req=1 addr=00 v=0", mem_req, mem_addr, inst_valid); end
    step();
    checks++; if ({mem_req, mem_addr, inst[15:8]} !== {1'b1, 8'h01, 8'h1A}) begin failures++; $display("FAIL basic_e2 got req=%b addr=%h hi=%h exp req=1 addr=01 hi=1A", mem_req, mem_addr, inst[15:8]); end
    step();
    checks++; if (inst !== 16'h1A23) begin failures++; $display("FAIL basic_inst got=%h exp=1A23", inst); end
    checks++; if (opcode !== 4'h1) begin failures++; $display("FAIL basic_opcode got=%h exp=1", opcode); end
    checks++; if ({inst_valid, inst_pc, mem_req} !== {1'b1, 8'h00, 1'b0}) begin failures++; $display("FAIL basic_e3 got v=%b pc=%h req=%b exp v=1 pc=00 req=0", inst_valid, inst_pc, mem_req); end
    step();
    checks++; if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 8'h02}) begin failures++; $display("FAIL basic_next got v=%b req=%b addr=%h exp v=0 req=1 addr=02", inst_valid, mem_req, mem_addr); end
  endtask

  // Second instruction arrives 3 cycles after the first with ready held
  task automatic test_back_to_back();
    step(); step();
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 16'h7C3E, 8'h02}) begin failures++; $display("FAIL b2b_second got v=%b inst=%h pc=%h exp v=1 inst=7C3E pc=02", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_wait_states();
    waits = 2; inst_ready = 1'b1;
    do_reset();
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 8'h00, 1'b0}) begin failures++; $display("FAIL wait_hi_hold%0d got req=%b addr=%h v=%b exp req=1 addr=00 v=0", i, mem_req, mem_addr, inst_valid); end
    end
    step();
    checks++; if ({mem_addr, inst[15:8]} !== {8'h01, 8'h1A}) begin failures++; $display("FAIL wait_hi got addr=%h hi=%h exp addr=01 hi=1A", mem_addr, inst[15:8]); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 8'h01, 1'b0}) begin failures++; $display("FAIL wait_lo_hold%0d got req=%b addr=%h v=%b exp req=1 addr=01 v=0", i, mem_req, mem_addr, inst_valid); end
    end
    step();
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 16'h1A23, 8'h00}) begin failures++; $display("FAIL wait_done got v=%b inst=%h pc=%h exp v=1 inst=1A23 pc=00", inst_valid, inst, inst_pc); end
    waits = 0;
  endtask

  task automatic test_stall();
    waits = 0; inst_ready = 1'b0;
    do_reset();
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({inst_valid, inst, opcode, inst_pc, mem_req} !== {1'b1, 16'h1A23, 4'h1, 8'h00, 1'b0}) begin failures++; $display("FAIL stall_hold%0d got v=%b inst=%h op=%h pc=%h req=%b", i, inst_valid, inst, opcode, inst_pc, mem_req); end
    end
    inst_ready = 1'b1;
    step();
    checks++; if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 8'h02}) begin failures++; $display("FAIL stall_resume got v=%b req=%b addr=%h exp v=0 req=1 addr=02", inst_valid, mem_req, mem_addr); end
  endtask

  task automatic test_redirect_lo();
    waits = 0; inst_ready = 1'b1;
    do_reset();
    step(); step();
    redirect = 1'b1; redirect_pc = 8'h41;
    step();
    redirect = 1'b0;
    checks++; if ({mem_req, mem_addr, inst_valid, inst} !== {1'b1, 8'h41, 1'b0, 16'h1A00}) begin failures++; $display("FAIL redir_lo got req=%b addr=%h v=%b inst=%h exp req=1 addr=41 v=0 inst=1A00", mem_req, mem_addr, inst_valid, inst); end
    step(); step();
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 16'h9B6E, 8'h41}) begin failures++; $display("FAIL redir_lo_inst got v=%b inst=%h pc=%h exp v=1 inst=9B6E pc=41", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_redirect_out();
    waits = 0; inst_ready = 1'b0;
    do_reset();
    step(); step(); step();
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'h10;
    step();
    redirect = 1'b0;
    checks++; if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 8'h10}) begin failures++; $display("FAIL redir_out got v=%b req=%b addr=%h exp v=0 req=1 addr=10", inst_valid, mem_req, mem_addr); end
    step(); step();
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 16'h4F81, 8'h10}) begin failures++; $display("FAIL redir_out_inst got v=%b inst=%h pc=%h exp v=1 inst=4F81 pc=10", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_redirect_chain();
    waits = 0; inst_ready = 1'b1;
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 8'h20;
    step();
    redirect_pc = 8'h30;
    step();
    redirect = 1'b0;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 8'h30}) begin failures++; $display("FAIL redir_chain got req=%b addr=%h exp req=1 addr=30", mem_req, mem_addr); end
    step(); step();
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 16'hE25D, 8'h30}) begin failures++; $display("FAIL redir_chain_inst got v=%b inst=%h pc=%h exp v=1 inst=E25D pc=30", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_async_reset();
    waits = 0; inst_ready = 1'b1;
    rst = 1'b1; step();
    redirect = 1'b1; redirect_pc = 8'h41;
    rst = 1'b0;
    step();
    redirect = 1'b0;
    step();
    checks++; if ({mem_req, mem_addr, inst} !== {1'b1, 8'h42, 16'h9B00}) begin failures++; $display("FAIL arst_pre got req=%b addr=%h inst=%h exp req=1 addr=42 inst=9B00", mem_req, mem_addr, inst); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_req, mem_addr, inst, inst_pc, inst_valid} !== {1'b0, 8'h00, 16'h0000, 8'h00, 1'b0}) begin failures++; $display("FAIL arst_async got req=%b addr=%h inst=%h pc=%h v=%b exp all zero", mem_req, mem_addr, inst, inst_pc, inst_valid); end
    step();
    rst = 1'b0;
    step();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin failures++; $display("FAIL arst_restart got req=%b addr=%h exp req=1 addr=00", mem_req, mem_addr); end
    step(); step();
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 16'h1A23, 8'h00}) begin failures++; $display("FAIL arst_inst got v=%b inst=%h pc=%h exp v=1 inst=1A23 pc=00", inst_valid, inst, inst_pc); end
  endtask

  // Redirect held through the reset-release edge; fetch straddles 0xFF -> 0x00
  task automatic test_wrap();
    waits = 0; inst_ready = 1'b1;
    mem[8'h00] = 8'h07;
    rst = 1'b1; step();
    redirect = 1'b1; redirect_pc = 8'hFF;
    rst = 1'b0;
    step();
    redirect = 1'b0;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 8'hFF}) begin failures++; $display("FAIL wrap_req got req=%b addr=%h exp req=1 addr=FF", mem_req, mem_addr); end
    step();
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL wrap_lo_addr got=%h exp=00", mem_addr); end
    step();
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 16'hC507, 8'hFF}) begin failures++; $display("FAIL wrap_inst got v=%b inst=%h pc=%h exp v=1 inst=C507 pc=FF", inst_valid, inst, inst_pc); end
    checks++; if (opcode !== 4'hC) begin failures++; $display("FAIL wrap_opcode got=%h exp=C", opcode); end
    step();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 8'h01}) begin failures++; $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=01", mem_req, mem_addr); end
    mem[8'h00] = 8'h1A;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h00] = 8'h1A; mem[8'h01] = 8'h23;
    mem[8'h02] = 8'h7C; mem[8'h03] = 8'h3E;
    mem[8'h10] = 8'h4F; mem[8'h11] = 8'h81;
    mem[8'h30] = 8'hE2; mem[8'h31] = 8'h5D;
    mem[8'h41] = 8'h9B; mem[8'h42] = 8'h6E;
    mem[8'hFF] = 8'hC5;
    #3;
    test_reset();
    test_basic();
    test_back_to_back();
    test_wait_states();
    test_stall();
    test_redirect_lo();
    test_redirect_out();
    test_redirect_chain();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
